uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_bit_timer.sv | 28 ++
 rtl/uart_tx_cfg.sv | 136 +++++++++++++
 tb/tb_uart_tx_cfg.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and a parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  localparam int unsigned MAX_DATA_BITS = 9;

  // Even parity is the XOR of the payload; odd is its inverse. Unused upper bits must be zero.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input int unsigned               mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_end = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS payload LSB first, optional parity,
// one or two stop bits. Serial line and handshake outputs come straight from flops.
module uart_tx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  import uart_pkg::*;

  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  if ((CLKS_PER_BIT < 2) || (CLKS_PER_BIT > 65535)) begin : g_bad_clks_per_bit
    $fatal(1, "uart_tx_cfg: CLKS_PER_BIT=%0d outside 2..65535", CLKS_PER_BIT);
  end
  if ((DATA_BITS < 5) || (DATA_BITS > MAX_DATA_BITS)) begin : g_bad_data_bits
    $fatal(1, "uart_tx_cfg: DATA_BITS=%0d outside 5..9", DATA_BITS);
  end
  if (PARITY > PARITY_EVEN) begin : g_bad_parity
    $fatal(1, "uart_tx_cfg: PARITY=%0d not 0, 1 or 2", PARITY);
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $fatal(1, "uart_tx_cfg: STOP_BITS=%0d not 1 or 2", STOP_BITS);
  end

  uart_state_e          state;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic                 restart;
  logic                 bit_end;
  logic                 last_stop;

  // Counter is held at zero while idle so the start bit gets a full period.
  assign restart   = (state == ST_IDLE);
  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .bit_end(bit_end)
  );

  // Decoded from flops only: high on the last cycle of the final stop bit.
  assign tx_done = (state == ST_STOP) && last_stop && bit_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tx_valid && tx_ready) begin
            shift_q   <= tx_data;
            par_q     <= parity_bit(MAX_DATA_BITS'(tx_data), PARITY);
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            state     <= ST_START;
            tx_serial <= 1'b0;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state     <= ST_DATA;
            tx_serial <= shift_q[0];
            shift_q   <= shift_q >> 1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              if (PARITY != PARITY_NONE) begin
                state     <= ST_PARITY;
                tx_serial <= par_q;
              end else begin
                state     <= ST_STOP;
                tx_serial <= 1'b1;
              end
            end else begin
              bit_idx   <= bit_idx + IDX_W'(1);
              tx_serial <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state     <= ST_STOP;
            tx_serial <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              state    <= ST_IDLE;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          tx_serial <= 1'b1;
          tx_ready  <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations (8N1, 8E1, 8O1, 7N2) at CLKS_PER_BIT=4,
// a frame-level reference model checked every cycle, plus hand-computed frame literals.
module tb_uart_tx_cfg;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] val;
  logic [3:0] ser;
  logic [3:0] rdy;
  logic [3:0] bsy;
  logic [3:0] dn;
  logic [7:0] dat [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[0]), .tx_valid(val[0]),
    .tx_ready(rdy[0]), .tx_serial(ser[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));
  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[1]), .tx_valid(val[1]),
    .tx_ready(rdy[1]), .tx_serial(ser[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));
  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[2]), .tx_valid(val[2]),
    .tx_ready(rdy[2]), .tx_serial(ser[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));
  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[3][6:0]), .tx_valid(val[3]),
    .tx_ready(rdy[3]), .tx_serial(ser[3]), .tx_busy(bsy[3]), .tx_done(dn[3]));

  function automatic int db_of(input int i);
    return (i == 3) ? 7 : 8;
  endfunction
  function automatic int par_of(input int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction
  function automatic int sb_of(input int i);
    return (i == 3) ? 2 : 1;
  endfunction
  function automatic int nb_of(input int i);
    return 1 + db_of(i) + ((par_of(i) != 0) ? 1 : 0) + sb_of(i);
  endfunction

  // Frame as a bit list in transmission order: bit 0 is the start bit.
  function automatic logic [15:0] frame_of(input int i, input logic [7:0] d);
    logic [15:0] f = '0;
    int n = 1;
    int ones = 0;
    for (int j = 0; j < db_of(i); j++) begin
      f[n] = d[j];
      ones += int'(d[j]);
      n++;
    end
    if (par_of(i) != 0) begin
      f[n] = (par_of(i) == 2) ? 1'(ones % 2) : 1'(1 - (ones % 2));
      n++;
    end
    for (int s = 0; s < sb_of(i); s++) begin
      f[n] = 1'b1;
      n++;
    end
    return f;
  endfunction

  task automatic chk_bit(input string nm, input int i, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0t got=%b exp=%b", nm, i, $time, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
    end
  endtask

  // Reference model: idle, or position m_t within a frame of known bits.
  bit          m_act  [4];
  int          m_t    [4];
  logic [15:0] m_bits [4];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        m_act[i] <= 1'b0;
        m_t[i]   <= 0;
      end else if (m_act[i]) begin
        if (m_t[i] == nb_of(i) * CPB - 1) m_act[i] <= 1'b0;
        else m_t[i] <= m_t[i] + 1;
      end else if (val[i]) begin
        m_bits[i] <= frame_of(i, dat[i]);
        m_t[i]    <= 0;
        m_act[i]  <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 4; i++) begin
      chk_bit("model_serial", i, ser[i], m_act[i] ? m_bits[i][m_t[i] / CPB] : 1'b1);
      chk_bit("model_ready", i, rdy[i], !m_act[i]);
      chk_bit("model_busy", i, bsy[i], m_act[i]);
      chk_bit("model_done", i, dn[i], m_act[i] && (m_t[i] == nb_of(i) * CPB - 1));
    end
  end

  // Offer one frame at the current negedge and check it against a literal bit list.
  task automatic run_frame(input int i, input logic [7:0] d, input logic [15:0] exp,
                           input int nb, input bit tog, input string nm);
    logic cap [0:255];
    int   low = 0;
    int   dcnt = 0;
    int   done_at = 0;
    bit   ended = 0;
    logic [3:0] v;
    dat[i] = d;
    val[i] = 1'b1;
    @(negedge clk);
    val[i] = 1'b0;
    if (tog) begin
      val[i] = 1'($urandom);
      dat[i] = 8'($urandom);
    end
    for (int c = 1; c <= 200; c++) begin
      #2;
      if (rdy[i]) begin
        ended = 1;
        break;
      end
      low++;
      cap[c - 1] = ser[i];
      if (dn[i]) begin
        dcnt++;
        done_at = c;
      end
      @(negedge clk);
      if (tog) begin
        if (c + 1 < nb * CPB) begin
          val[i] = 1'($urandom);
          dat[i] = 8'($urandom);
        end else begin
          val[i] = 1'b0;
        end
      end
    end
    val[i] = 1'b0;
    chk_int({nm, "_ended"}, int'(ended), 1);
    chk_int({nm, "_ready_low_cycles"}, low, nb * CPB);
    chk_int({nm, "_done_count"}, dcnt, 1);
    chk_int({nm, "_done_cycle"}, done_at, nb * CPB);
    for (int k = 0; k < nb; k++) begin
      v = {cap[k*CPB+3], cap[k*CPB+2], cap[k*CPB+1], cap[k*CPB]};
      chk_int($sformatf("%s_bit%0d", nm, k), int'(v), exp[k] ? 15 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic cap [0:127];
    int   idle_at;
    int   idle_cnt;
    int   dcnt;
    int   d_at [2];
    int   low_cnt;

    rst_n = 1'b0;
    val   = '0;
    for (int i = 0; i < 4; i++) dat[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_int("reset_serial", int'(ser), 15);
    chk_int("reset_ready", int'(rdy), 15);
    chk_int("reset_busy", int'(bsy), 0);
    chk_int("reset_done", int'(dn), 0);
    chk_int("model_pin_8n1_a5", int'(frame_of(0, 8'hA5)), 16'b1101001010);
    chk_int("model_pin_8o1_07", int'(frame_of(2, 8'h07)), 16'b10000001110);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk); run_frame(0, 8'hA5, 16'b1101001010,  10, 0, "8n1_a5");
    @(negedge clk); run_frame(1, 8'h07, 16'b11000001110, 11, 0, "8e1_07");
    @(negedge clk); run_frame(2, 8'h07, 16'b10000001110, 11, 0, "8o1_07");
    @(negedge clk); run_frame(3, 8'h41, 16'b1110000010,  10, 0, "7n2_41");

    // Back-to-back: tx_valid held while the first frame is in flight.
    @(negedge clk);
    dat[0] = 8'h55;
    val[0] = 1'b1;
    @(negedge clk);
    dat[0] = 8'hAA;
    idle_at = 0; idle_cnt = 0; dcnt = 0; d_at[0] = 0; d_at[1] = 0;
    for (int c = 1; c <= 90; c++) begin
      #2;
      if (rdy[0] && idle_at == 0) idle_at = c;
      if (rdy[0] && c <= 81) idle_cnt++;
      if (dn[0]) begin
        if (dcnt < 2) d_at[dcnt] = c;
        dcnt++;
      end
      cap[c] = ser[0];
      @(negedge clk);
      if (idle_at != 0) val[0] = 1'b0;
    end
    chk_int("b2b_idle_cycle", idle_at, 41);
    chk_int("b2b_idle_count", idle_cnt, 1);
    chk_int("b2b_done_count", dcnt, 2);
    chk_int("b2b_done1_cycle", d_at[0], 40);
    chk_int("b2b_done2_cycle", d_at[1], 81);
    chk_int("b2b_gap_high", int'(cap[41]), 1);
    chk_int("b2b_second_start", int'(cap[42]), 0);
    chk_int("b2b_second_d0", int'(cap[47]), 0);
    chk_int("b2b_second_d1", int'(cap[51]), 1);

    // Abort mid-frame during data bit 3 (cycles 17..20) with an all-zero payload.
    @(negedge clk);
    dat[0] = 8'h00;
    val[0] = 1'b1;
    @(negedge clk);
    val[0] = 1'b0;
    repeat (17) @(negedge clk);
    #2;
    chk_int("abort_pre_serial", int'(ser[0]), 0);
    chk_int("abort_pre_busy", int'(bsy[0]), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_int("abort_serial", int'(ser[0]), 1);
    chk_int("abort_ready", int'(rdy[0]), 1);
    chk_int("abort_busy", int'(bsy[0]), 0);
    chk_int("abort_done", int'(dn[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0; low_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      #2;
      if (dn[0]) dcnt++;
      if (!ser[0]) low_cnt++;
      @(negedge clk);
    end
    chk_int("abort_no_done", dcnt, 0);
    chk_int("abort_line_idle", low_cnt, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 8'h3C, 16'b1001111000, 10, 0, "after_reset_3c");

    // Inputs toggled during the frame must not disturb it.
    @(negedge clk); run_frame(1, 8'h07, 16'b11000001110, 11, 1, "8e1_toggle");
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
